// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Fetch-stage bundle: PC, instruction ROM and decoder handshake signals.
interface fetch_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 8
);
  logic [ADDR_W-1:0]         pc_in;
  logic                      pc_en;
  logic                      halt;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_rd;
  logic [INSTR_W-1:0]        mem_data;
  logic [INSTR_W-1:0]        ir_out;
  logic [INSTR_W-ADDR_W-1:0] opcode;
  logic [ADDR_W-1:0]         operand;
  logic                      ir_valid;
  logic                      ir_ready;
  logic [CNT_W-1:0]          instr_cnt;

  modport master (
    input  pc_in, halt, mem_data, ir_ready,
    output pc_en, mem_addr, mem_rd, ir_out, opcode, operand, ir_valid, instr_cnt
  );

  modport slave (
    output pc_in, halt, mem_data, ir_ready,
    input  pc_en, mem_addr, mem_rd, ir_out, opcode, operand, ir_valid, instr_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Four-state instruction fetch: PC -> MAR -> ROM read -> IR -> decoder handshake.
module fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         res,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_rd;
  logic               r_pc_en;
  logic               r_ir_valid;
  logic [INSTR_W-1:0] r_ir_out;
  logic [CNT_W-1:0]   r_instr_cnt;

  // Strobes are registered alongside the next state so each equals a decode of r_state.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= S_ADDR;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_pc_en     <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_ir_out    <= '0;
      r_instr_cnt <= '0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (!bus.halt) begin
            r_mem_addr <= bus.pc_in;
            r_mem_rd   <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_mem_rd <= 1'b0;
          r_pc_en  <= 1'b1;
          r_state  <= S_LATCH;
        end
        S_LATCH: begin
          r_ir_out    <= bus.mem_data;
          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
          r_pc_en     <= 1'b0;
          r_ir_valid  <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_state    <= S_ADDR;
          end
        end
        default: begin
          r_mem_rd   <= 1'b0;
          r_pc_en    <= 1'b0;
          r_ir_valid <= 1'b0;
          r_state    <= S_ADDR;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.pc_en     = r_pc_en;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.ir_out    = r_ir_out;
  assign bus.opcode    = r_ir_out[INSTR_W-1:ADDR_W];
  assign bus.operand   = r_ir_out[ADDR_W-1:0];
  assign bus.instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Directed bench for fetch_unit with a PC counter and synchronous ROM model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(4), .INSTR_W(8), .CNT_W(8)) bus ();

  fetch_unit #(.ADDR_W(4), .INSTR_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  logic [7:0] rom [16];
  logic [7:0] rom_q = 8'h00;
  logic [3:0] pc = 4'h0;
  logic       pc_load = 1'b0;
  logic [3:0] pc_load_val = 4'h0;
  int         rd_cnt = 0;
  int         pe_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  // External program counter: cleared by res, advanced by pc_en, bench may preload it.
  always_ff @(posedge clk) begin
    if (res)          pc <= 4'h0;
    else if (pc_load) pc <= pc_load_val;
    else if (bus.pc_en) pc <= pc + 4'h1;
  end

  always_ff @(posedge clk) begin
    if (bus.mem_rd) rom_q <= rom[bus.mem_addr];
  end

  always_ff @(posedge clk) begin
    if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
    if (bus.pc_en)  pe_cnt <= pe_cnt + 1;
  end

  assign bus.pc_in    = pc;
  assign bus.mem_data = rom_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd();
    int n = 0;
    while (bus.mem_rd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_start", {31'd0, bus.mem_rd}, 32'd1);
  endtask

  task automatic fetch_one(input logic [3:0] a, input logic [7:0] d);
    wait_rd();
    check("mem_addr", {28'd0, bus.mem_addr}, {28'd0, a});
    @(negedge clk);
    check("pc_en", {31'd0, bus.pc_en}, 32'd1);
    @(negedge clk);
    check("ir_valid", {31'd0, bus.ir_valid}, 32'd1);
    check("ir_out", {24'd0, bus.ir_out}, {24'd0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int rd0;
    int pe0;
    logic [3:0] e;
    for (int n = 0; n < 16; n++) rom[n] = {n[3:0], ~n[3:0]};
    rom[0] = 8'h1E;
    res = 1'b1;
    bus.halt = 1'b0;
    bus.ir_ready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("rst_pc_en", {31'd0, bus.pc_en}, 32'd0);
    check("rst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("rst_ir_out", {24'd0, bus.ir_out}, 32'h00);
    check("rst_instr_cnt", {24'd0, bus.instr_cnt}, 32'd0);
    check("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    res = 1'b0;

    // Single fetch from PC 0
    @(negedge clk);
    check("c1_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    check("c1_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    check("c1_pc_en", {31'd0, bus.pc_en}, 32'd0);
    @(negedge clk);
    check("c2_pc_en", {31'd0, bus.pc_en}, 32'd1);
    check("c2_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("c2_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    @(negedge clk);
    check("c3_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
    check("c3_pc_en", {31'd0, bus.pc_en}, 32'd0);
    check("c3_opcode", {28'd0, bus.opcode}, 32'h1);
    check("c3_operand", {28'd0, bus.operand}, 32'hE);
    check("c3_instr_cnt", {24'd0, bus.instr_cnt}, 32'd1);

    // Backpressure
    bus.ir_ready = 1'b0;
    rd0 = rd_cnt;
    pe0 = pe_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
      check("bp_ir_out", {24'd0, bus.ir_out}, 32'h1E);
      check("bp_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    end
    check("bp_rd_pulses", rd_cnt - rd0, 32'd0);
    check("bp_pe_pulses", pe_cnt - pe0, 32'd0);
    bus.ir_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("bp_rel_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    @(negedge clk);
    check("bp_next_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    check("bp_next_mem_addr", {28'd0, bus.mem_addr}, 32'd1);

    // Halt raised mid-fetch: in-flight fetch completes, then fetch stalls
    bus.halt = 1'b1;
    @(negedge clk);
    check("h_pc_en", {31'd0, bus.pc_en}, 32'd1);
    @(negedge clk);
    check("h_ir_out", {24'd0, bus.ir_out}, 32'h1E);
    rd0 = rd_cnt;
    pe0 = pe_cnt;
    repeat (10) @(negedge clk);
    check("h_rd_pulses", rd_cnt - rd0, 32'd0);
    check("h_pe_pulses", pe_cnt - pe0, 32'd0);
    check("h_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("h_mem_addr", {28'd0, bus.mem_addr}, 32'd1);
    bus.halt = 1'b0;
    fetch_one(4'h2, 8'h2D);
    check("h_instr_cnt", {24'd0, bus.instr_cnt}, 32'd3);

    // Wrap through PC F -> 0
    rom[0] = 8'h0F;
    bus.halt = 1'b1;
    pc_load_val = 4'hD;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    bus.halt = 1'b0;
    fetch_one(4'hD, 8'hD2);
    fetch_one(4'hE, 8'hE1);
    fetch_one(4'hF, 8'hF0);
    fetch_one(4'h0, 8'h0F);
    check("w_instr_cnt7", {24'd0, bus.instr_cnt}, 32'd7);
    e = 4'h1;
    for (int k = 0; k < 248; k++) begin
      fetch_one(e, rom[e]);
      e = e + 4'h1;
    end
    check("w_instr_cnt_ff", {24'd0, bus.instr_cnt}, 32'hFF);
    fetch_one(e, rom[e]);
    check("w_instr_cnt_00", {24'd0, bus.instr_cnt}, 32'h00);

    // Reset during S_READ
    @(negedge clk);
    wait_rd();
    res = 1'b1;
    pe0 = pe_cnt;
    @(negedge clk);
    check("r_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("r_ir_out", {24'd0, bus.ir_out}, 32'h00);
    check("r_pc_en", {31'd0, bus.pc_en}, 32'd0);
    check("r_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("r_instr_cnt", {24'd0, bus.instr_cnt}, 32'd0);
    res = 1'b0;
    fetch_one(4'h0, 8'h0F);
    check("r_pe_before", pe_cnt - pe0, 32'd1);
    check("r_instr_cnt1", {24'd0, bus.instr_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
